// File: rtl/univ_bin_counter.sv
// Purpose: N-bit universal binary counter (clear, load, up/down count, enable) with terminal-count flags.
// Latency: one clk from sampled control to updated q; flags decode q combinationally in the same cycle.
// Backpressure: none; controls are level-sensitive and re-apply on every edge they are held.
module univ_bin_counter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sync_clr,
  input  logic         load,
  input  logic         en,
  input  logic         up,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic         max_tick,
  output logic         min_tick
);

  localparam logic [N-1:0] ALL_ONES = {N{1'b1}};
  localparam logic [N-1:0] ALL_ZERO = {N{1'b0}};
  localparam logic [N-1:0] ONE      = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] r_q;
  logic [N-1:0] r_d;

  // Next-state select: clear beats load, load beats counting, otherwise hold.
  // Modular add/sub in N bits gives the wrap at both ends for free.
  always_comb begin
    r_d = r_q;
    if (sync_clr) begin
      r_d = ALL_ZERO;
    end else if (load) begin
      r_d = d;
    end else if (en) begin
      if (up) begin
        r_d = r_q + ONE;
      end else begin
        r_d = r_q - ONE;
      end
    end
  end

  // Count register; synchronous active-low reset overrides every other control.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q <= ALL_ZERO;
    end else begin
      r_q <= r_d;
    end
  end

  assign q        = r_q;
  assign max_tick = (r_q == ALL_ONES);
  assign min_tick = (r_q == ALL_ZERO);

endmodule

// File: tb/tb_univ_bin_counter.sv
// Bench for univ_bin_counter: directed scenarios plus random controls against an arithmetic model.
// Inputs change 1 time unit after each rising edge; outputs are sampled 1 time unit after the edge.
// Model tracks the count as a plain integer modulo 2^N.
module tb_univ_bin_counter;

  localparam int N    = 8;
  localparam int MODV = 1 << N;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         sync_clr = 1'b0;
  logic         load = 1'b0;
  logic         en = 1'b0;
  logic         up = 1'b0;
  logic [N-1:0] d = '0;
  logic [N-1:0] q;
  logic         max_tick;
  logic         min_tick;

  int n_chk  = 0;
  int n_fail = 0;
  int model  = 0;

  univ_bin_counter #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .sync_clr (sync_clr),
    .load     (load),
    .en       (en),
    .up       (up),
    .d        (d),
    .q        (q),
    .max_tick (max_tick),
    .min_tick (min_tick)
  );

  always #5 clk = ~clk;

  // One rising edge: apply the control rules to the integer model, then settle.
  task automatic tick();
    @(posedge clk);
    if (!reset)        model = 0;
    else if (sync_clr) model = 0;
    else if (load)     model = int'(d);
    else if (en)       model = up ? (model + 1) % MODV : (model + MODV - 1) % MODV;
    #1;
  endtask

  task automatic set_ctl(input logic r, input logic c, input logic l,
                         input logic e, input logic u, input logic [N-1:0] dv);
    reset = r; sync_clr = c; load = l; en = e; up = u; d = dv;
  endtask

  task automatic test_reset();
    set_ctl(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h5A);
    tick(); tick();
    n_chk++;
    if (q !== 8'h00) begin n_fail++; $display("FAIL reset_q: got %h want 00", q); end
    n_chk++;
    if (min_tick !== 1'b1) begin n_fail++; $display("FAIL reset_min_tick: got %b want 1", min_tick); end
    n_chk++;
    if (max_tick !== 1'b0) begin n_fail++; $display("FAIL reset_max_tick: got %b want 0", max_tick); end
    reset = 1'b1;
    tick();
    n_chk++;
    if (q !== 8'h5A) begin n_fail++; $display("FAIL reset_release_load: got %h want 5a", q); end
  endtask

  task automatic test_count();
    logic [N-1:0] exp_seq [5];
    exp_seq = '{8'h01, 8'h02, 8'h03, 8'h02, 8'h01};
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    tick();
    set_ctl(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) begin
      if (i == 3) up = 1'b0;
      tick();
      n_chk++;
      if (q !== exp_seq[i]) begin
        n_fail++; $display("FAIL count_step%0d: got %h want %h", i, q, exp_seq[i]);
      end
    end
    en = 1'b0;
    tick(); tick();
    n_chk++;
    if (q !== 8'h01) begin n_fail++; $display("FAIL count_hold: got %h want 01", q); end
  endtask

  task automatic test_load_priority();
    set_ctl(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3F);
    tick();
    n_chk++;
    if (q !== 8'h3F) begin n_fail++; $display("FAIL load_no_en: got %h want 3f", q); end
    set_ctl(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h3F);
    tick();
    n_chk++;
    if (q !== 8'h3F) begin n_fail++; $display("FAIL load_over_en: got %h want 3f", q); end
    set_ctl(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h3F);
    tick();
    n_chk++;
    if (q !== 8'h00) begin n_fail++; $display("FAIL clr_over_load: got %h want 00", q); end
  endtask

  task automatic test_wrap();
    set_ctl(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFF);
    tick();
    n_chk++;
    if (max_tick !== 1'b1 || min_tick !== 1'b0) begin
      n_fail++; $display("FAIL wrap_max_flag: got max=%b min=%b want max=1 min=0", max_tick, min_tick);
    end
    set_ctl(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    tick();
    n_chk++;
    if (q !== 8'h00 || min_tick !== 1'b1 || max_tick !== 1'b0) begin
      n_fail++; $display("FAIL wrap_up: got q=%h min=%b max=%b want q=00 min=1 max=0", q, min_tick, max_tick);
    end
    up = 1'b0;
    tick();
    n_chk++;
    if (q !== 8'hFF || max_tick !== 1'b1 || min_tick !== 1'b0) begin
      n_fail++; $display("FAIL wrap_down: got q=%h max=%b min=%b want q=ff max=1 min=0", q, max_tick, min_tick);
    end
  endtask

  task automatic test_held_load();
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    tick();
    set_ctl(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++;
      if (q !== 8'hFF || max_tick !== 1'b1) begin
        n_fail++; $display("FAIL held_load%0d: got q=%h max=%b want q=ff max=1", i, q, max_tick);
      end
    end
  endtask

  task automatic test_reset_mid();
    set_ctl(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h44);
    tick();
    set_ctl(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    tick();
    n_chk++;
    if (q !== 8'h45) begin n_fail++; $display("FAIL mid_setup: got %h want 45", q); end
    reset = 1'b0;
    tick();
    n_chk++;
    if (q !== 8'h00) begin n_fail++; $display("FAIL mid_reset: got %h want 00", q); end
    reset = 1'b1;
    tick();
    n_chk++;
    if (q !== 8'h01) begin n_fail++; $display("FAIL mid_resume: got %h want 01", q); end
  endtask

  task automatic test_random();
    int exp_q;
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 39) != 0);
      sync_clr = ($urandom_range(0, 19) == 0);
      load     = ($urandom_range(0, 9) == 0);
      en       = ($urandom_range(0, 3) != 0);
      up       = ($urandom_range(0, 2) != 0);
      d        = ($urandom_range(0, 3) == 0) ? 8'hFF : N'($urandom);
      tick();
      exp_q = model;
      n_chk++;
      if (int'(q) !== exp_q || max_tick !== (exp_q == MODV - 1) || min_tick !== (exp_q == 0)) begin
        n_fail++;
        $display("FAIL random%0d: got q=%h max=%b min=%b want q=%h max=%b min=%b",
                 i, q, max_tick, min_tick, exp_q[N-1:0], (exp_q == MODV - 1), (exp_q == 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_load_priority();
    test_wrap();
    test_held_load();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/univ_bin_counter.md
Name: univ_bin_counter

Overview:
- Parameterizable N-bit universal binary counter: up/down counting, synchronous clear, parallel load, count enable.
- Combinational terminal-count flags at all-ones and zero.
- General-purpose building block for timers, address generators and event counters; single clock domain.

Parameters:
- N, default 8, counter width in bits (N >= 1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; when 0 at a rising clk edge, q becomes 0.
- sync_clr  input  1  synchronous clear, active-high.
- load  input  1  synchronous parallel load, active-high.
- en  input  1  count enable, active-high.
- up  input  1  count direction: 1 = increment, 0 = decrement.
- d  input  N  parallel load value.
- q  output  N  current count (registered).
- max_tick  output  1  high when q is all ones (2^N-1).
- min_tick  output  1  high when q is 0.

Behaviour:
- Single N-bit register r; q = r directly (no extra output stage).
- Reset: one clock domain only; reset is synchronous and active-low. reset=0 sampled at a rising clk edge forces r = 0, overriding all other inputs. There is no asynchronous path: between power-up and the first reset edge, q is undefined.
- Next-state priority, evaluated at each rising edge with reset=1, highest first:
  1. sync_clr=1 -> r = 0.
  2. load=1 -> r = d. Load does not require en.
  3. en=1 and up=1 -> r = r + 1 mod 2^N.
  4. en=1 and up=0 -> r = r - 1 mod 2^N.
  5. Otherwise r holds.
- Wrap-around:
  - Incrementing from 2^N-1 yields 0.
  - Decrementing from 0 yields 2^N-1.
  - No saturation and no sticky overflow flag.
- Latency: one clock from a sampled control to the updated q. Control inputs are level-sensitive; no handshake. Each cycle a control is held applies its action again (load held for k cycles reloads d every cycle).
- Flags: max_tick and min_tick are purely combinational decodes of r.
  - They update in the same cycle q changes.
  - Both are independent of en and up.
  - Reset value: max_tick=0, min_tick=1.
  - For N>=1 the two flags are never high together.
- Simultaneous controls resolve strictly by the priority above, e.g. sync_clr=1 with load=1 gives 0; load=1 with en=1 gives d.
- up changes take effect on the next enabled edge. Toggling up mid-count reverses direction from the current value with no skipped or repeated step.
- Reset mid-operation (any state) returns q to 0 on that edge. Counting resumes from 0 on the first edge after reset returns high.
- All inputs are sampled synchronously to clk; d is only sampled when load has effect.

Test Plan:
- Reset: reset=0 for 2 edges with en=1, up=1, load=1 -> q=0x00, min_tick=1, max_tick=0; after reset=1, the next edge loads d.
- Count up: reset=1, en=1, up=1 from 0x00 for 3 edges -> q=0x01, 0x02, 0x03. Then up=0 for 2 edges -> q=0x02, 0x01. Then en=0 -> q holds 0x01.
- Load and priority: d=0x3F, load=1 for one edge with en=0 -> q=0x3F. With load=1, en=1, up=1 -> q=0x3F, not incremented. With sync_clr=1, load=1 -> q=0x00.
- Wrap: load d=0xFF -> max_tick=1. Then en=1, up=1, one edge -> q=0x00, min_tick=1. Then up=0, one edge -> q=0xFF, max_tick=1.
- Held load: load=1 held 5 edges with d=0xFF and en=1 -> q stays 0xFF and max_tick stays 1 throughout.
- Reset mid-count: counting up at q=0x45, assert reset=0 for one edge -> q=0x00. Release with en=1, up=1 -> q=0x01 on the next edge.
